// File: rtl/mantissa_normalizer.sv
// ============================================================================
// Module      : mantissa_normalizer
// Description : Two-stage FP mantissa normalizer (leading-zero count, then
//               log-depth left shift) with valid/ready on both sides.
//               Optional macro NORM_SUBNORMAL_EN selects gradual underflow.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mantissa_normalizer #(
  parameter int N   = 24,
  parameter int SEL = 5,
  parameter int E   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_sign_i,
  input  logic [E-1:0] in_exp_i,
  input  logic [N-1:0] in_mant_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         out_sign_o,
  output logic [E-1:0] out_exp_o,
  output logic [N-1:0] out_mant_o,
  output logic         out_zero_o,
  output logic         out_uflow_o
);

  localparam int LZW = SEL + 1;
  localparam int XW  = ((E > LZW) ? E : LZW) + 1;

  logic           w_s1_adv, w_s2_adv;
  logic           s1_valid_q, s1_sign_q;
  logic [E-1:0]   s1_exp_q;
  logic [N-1:0]   s1_mant_q;
  logic [LZW-1:0] s1_lz_q, lz_d;
  logic           s2_valid_q;

  assign w_s2_adv    = !s2_valid_q || out_ready_i;
  assign w_s1_adv    = !s1_valid_q || w_s2_adv;
  assign in_ready_o  = w_s1_adv;
  assign out_valid_o = s2_valid_q;

  // Last set bit found while scanning upward is the MSB; all-zero gives N.
  always_comb begin
    lz_d = LZW'(N);
    for (int i = 0; i < N; i++) begin
      if (in_mant_i[i]) lz_d = LZW'(N - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_lz_q    <= '0;
    end else if (w_s1_adv) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_sign_q <= in_sign_i;
        s1_exp_q  <= in_exp_i;
        s1_mant_q <= in_mant_i;
        s1_lz_q   <= lz_d;
      end
    end
  end

  logic            w_zero, w_uflow;
  logic [XW-1:0]   w_exp_x, w_lz_x;
  logic [E-1:0]    w_exp_norm;
  logic [SEL-1:0]  w_amt;
  logic [N-1:0]    w_stg [0:SEL];

  assign w_zero     = (s1_mant_q == '0);
  assign w_exp_x    = XW'(s1_exp_q);
  assign w_lz_x     = XW'(s1_lz_q);
  assign w_uflow    = !w_zero && (w_lz_x >= w_exp_x);
  assign w_exp_norm = s1_exp_q - E'(s1_lz_q);

`ifdef NORM_SUBNORMAL_EN
  // Underflow shifts only far enough to land the exponent on the subnormal floor.
  logic [SEL-1:0] w_sub_shift;
  assign w_sub_shift = (s1_exp_q == '0) ? '0 : SEL'(s1_exp_q - E'(1));
  assign w_amt       = w_uflow ? w_sub_shift : s1_lz_q[SEL-1:0];
`else
  assign w_amt = s1_lz_q[SEL-1:0];
`endif

  assign w_stg[0] = s1_mant_q;
  for (genvar s = 0; s < SEL; s++) begin : g_shift
    assign w_stg[s+1] = w_amt[s] ? (w_stg[s] << (2**s)) : w_stg[s];
  end

  logic         sign_d, zero_d, uflow_d;
  logic [E-1:0] exp_d;
  logic [N-1:0] mant_d;

  always_comb begin
    sign_d  = s1_sign_q;
    exp_d   = w_exp_norm;
    mant_d  = w_stg[SEL];
    zero_d  = 1'b0;
    uflow_d = 1'b0;
    if (w_zero) begin
      exp_d  = '0;
      mant_d = '0;
      zero_d = 1'b1;
    end else if (w_uflow) begin
      exp_d   = '0;
      uflow_d = 1'b1;
`ifndef NORM_SUBNORMAL_EN
      mant_d  = '0;
      zero_d  = 1'b1;
`endif
    end
  end

  // Payload only moves when stage 2 advances with a real beat, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      out_sign_o  <= 1'b0;
      out_exp_o   <= '0;
      out_mant_o  <= '0;
      out_zero_o  <= 1'b0;
      out_uflow_o <= 1'b0;
    end else if (w_s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_o  <= sign_d;
        out_exp_o   <= exp_d;
        out_mant_o  <= mant_d;
        out_zero_o  <= zero_d;
        out_uflow_o <= uflow_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mantissa_normalizer.sv
// ============================================================================
// Module      : tb_mantissa_normalizer
// Description : Self-checking bench: directed cases, backpressure, reset and
//               randomized scoreboard against an arithmetic reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        out_valid, out_ready, out_sign, out_zero, out_uflow;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];
  logic        hold_f = 1'b0;
  logic [34:0] hold_pl;

  mantissa_normalizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_sign_i  (in_sign),
    .in_exp_i   (in_exp),
    .in_mant_i  (in_mant),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sign_o (out_sign),
    .out_exp_o  (out_exp),
    .out_mant_o (out_mant),
    .out_zero_o (out_zero),
    .out_uflow_o(out_uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [34:0] dut_pl();
    return {out_sign, out_exp, out_mant, out_zero, out_uflow};
  endfunction

  // Reference: normalize by repeated doubling, then apply exponent rules in integers.
  function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [23:0] m);
    int lz, ee;
    logic [23:0] mm;
    if (m == 24'd0) return {s, 8'd0, 24'd0, 1'b1, 1'b0};
    lz = 0;
    mm = m;
    while (!mm[23]) begin
      mm = mm << 1;
      lz++;
    end
    ee = int'(e);
    if (lz < ee) return {s, 8'(ee - lz), mm, 1'b0, 1'b0};
`ifdef NORM_SUBNORMAL_EN
    mm = m << ((ee == 0) ? 0 : ee - 1);
    return {s, 8'd0, mm, 1'b0, 1'b1};
`else
    return {s, 8'd0, 24'd0, 1'b1, 1'b1};
`endif
  endfunction

  // One clock: inputs already driven at the falling edge; settle, score, advance.
  task automatic step(output logic acc, output logic emit);
    logic [34:0] want;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        want = exp_q.pop_front();
        chk("scoreboard", dut_pl(), want);
      end
    end
    if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant));
    hold_f  = out_valid && !out_ready;
    hold_pl = dut_pl();
    @(posedge clk);
    @(negedge clk);
    if (hold_f) chk("stall_stable", {out_valid, dut_pl()}, {1'b1, hold_pl});
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [23:0] m, input logic [34:0] want);
    logic acc, emit;
    int   lat;
    out_ready = 1'b1;
    drive(s, e, m);
    step(acc, emit);
    chk({tag, "_acc"}, acc, 1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      step(acc, emit);
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_val"}, dut_pl(), want);
    step(acc, emit);
  endtask

  task automatic rand_beat();
    int lzr;
    lzr = $urandom_range(0, 24);
    in_valid = 1'b1;
    in_sign  = 1'($urandom);
    in_mant  = (lzr == 24) ? 24'd0 : ({1'b1, 23'($urandom)} >> lzr);
    in_exp   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
  endtask

  initial begin
    logic acc, emit;
    int   k, n_emit, n_acc, cyc;
    logic [23:0] bp_m [4];

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", dut_pl(), 0);

    directed("t1_norm", 1'b1, 8'd100, 24'h000F00, {1'b1, 8'd88, 24'hF00000, 2'b00});
    directed("t2_pass", 1'b0, 8'd5, 24'h800000, {1'b0, 8'd5, 24'h800000, 2'b00});
    directed("t2_lsb", 1'b0, 8'd30, 24'h000001, {1'b0, 8'd7, 24'h800000, 2'b00});
    directed("t3_zero", 1'b1, 8'd77, 24'h000000, {1'b1, 8'd0, 24'h000000, 2'b10});
`ifdef NORM_SUBNORMAL_EN
    directed("t4_uflow", 1'b0, 8'd10, 24'h000100, {1'b0, 8'd0, 24'h020000, 2'b01});
    directed("t4_exp0", 1'b1, 8'd0, 24'h000400, {1'b1, 8'd0, 24'h000400, 2'b01});
`else
    directed("t4_uflow", 1'b0, 8'd10, 24'h000100, {1'b0, 8'd0, 24'h000000, 2'b11});
    directed("t4_exp0", 1'b1, 8'd0, 24'h000400, {1'b1, 8'd0, 24'h000000, 2'b11});
`endif
    directed("t4_edge", 1'b0, 8'd9, 24'h008000, model(1'b0, 8'd9, 24'h008000));

    // Backpressure: four beats against a stalled sink.
    bp_m[0] = 24'h000F00; bp_m[1] = 24'h123456; bp_m[2] = 24'h000003; bp_m[3] = 24'h0000A0;
    out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'(i), 8'(60 + i), bp_m[k]);
      step(acc, emit);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    #1;
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    n_emit = 0;
    for (int i = 0; i < 4; i++) begin
      if (k < 4) drive(1'(k), 8'(60 + k), bp_m[k]);
      else in_valid = 1'b0;
      step(acc, emit);
      if (acc) k++;
      if (emit) n_emit++;
    end
    chk("bp_emit_rate", n_emit, 4);
    chk("bp_all_in", k, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step(acc, emit);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive(1'b0, 8'd50, 24'h00FFFF); step(acc, emit);
    drive(1'b1, 8'd40, 24'h0F0000); step(acc, emit);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_payload", dut_pl(), 0);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    hold_f = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    directed("post_rst", 1'b1, 8'd100, 24'h000F00, {1'b1, 8'd88, 24'hF00000, 2'b00});

    // Randomized traffic with random backpressure.
    n_acc = 0;
    cyc = 0;
    acc = 1'b1;
    in_valid = 1'b0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) rand_beat();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc, emit);
      if (acc) n_acc++;
      cyc++;
    end
    chk("rand_accepted", n_acc, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(acc, emit);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
